master_pclk: RTL and testbench
==============================

MASTER_PCLK -- requirements
Module: master_pclk

Interface
REQ-001 SHALL have the following ports (clock and reset first).
- PCLK in 1: sole clock; every register SHALL be updated on its rising edge.
- RESETn_pclk in 1: reset, synchronous and active-high (1 = reset).
- CMD in 3: user command.
- ADDR in 10: user address.
- WDATA in 10: user write data.
- ABORT in 1: user abort flag.
- READY_pclk out 1: block idle, can accept a command.
- RDATA_pclk out 10: read data returned to the user.
- RESP_pclk out 1: one-cycle completion pulse.
- RDATA_sclk in 10: slave read data, SCLK domain; held stable by the slave while ack_sclk=1.
- CMD_REG_pclk out 3, ADDR_REG_pclk out 10, WDATA_REG_pclk out 10, ABORT_REG_pclk out 1: quasi-static bus to the slave.
- req_pclk out 1: handshake request.
- ack_sclk in 1: slave acknowledge, asynchronous.
- ack_pclk out 1: ack_sclk after the 2-FF synchronizer.
- req_sclk in 1: slave-side synchronized request, monitor only; it SHALL have no functional effect.
REQ-002 Command codes SHALL be: IDLE=0, READ=1, WRITE=2, ROW_WRITE=3, ERASE=4, MASS_ERASE=5. Codes 6 and 7 are invalid.

Function
REQ-003 The FSM SHALL have the states S_IDLE, S_SETUP, S_REQ, S_DROP.
REQ-004 READY_pclk SHALL be 1 only in S_IDLE.
REQ-005 In S_IDLE, at a rising edge with CMD in 1..5, the block SHALL:
- load CMD, ADDR, WDATA and ABORT into the *_REG_pclk registers;
- go to S_SETUP.
CMD=0, 6 or 7 SHALL be ignored.
REQ-006 S_SETUP SHALL last exactly one cycle with req_pclk=0, then go to S_REQ. This gives data a one-cycle setup before the request.
REQ-007 In S_REQ, req_pclk SHALL be 1. The FSM SHALL stay in S_REQ until ack_pclk=1, then go to S_DROP.
REQ-008 On the S_REQ->S_DROP edge, if CMD_REG_pclk=READ, RDATA_pclk SHALL load RDATA_sclk. Otherwise RDATA_pclk SHALL hold its value.
REQ-009 In S_DROP, req_pclk SHALL be 0. On the first edge with ack_pclk=0 the block SHALL:
- go to S_IDLE;
- set RESP_pclk=1 for exactly that next cycle.
READY_pclk SHALL rise in the same cycle as RESP_pclk.
REQ-010 req_pclk SHALL be a direct flop output, glitch-free, with no combinational path from any input.
REQ-011 The *_REG_pclk outputs SHALL remain constant from load until return to S_IDLE. CMD, ADDR, WDATA and ABORT changes while busy SHALL be ignored.
REQ-012 ABORT asserted while not in S_IDLE SHALL set ABORT_REG_pclk=1 at the next edge. ABORT_REG_pclk SHALL remain 1 until the next command load. The handshake SHALL still complete normally; there is no early exit.
REQ-013 ack_pclk SHALL be the second stage of a 2-flop synchronizer of ack_sclk. ack_sclk SHALL reach no other logic.
REQ-014 A valid CMD on the same edge that RESP_pclk is issued SHALL NOT be accepted. Acceptance requires READY_pclk=1 at that edge.
REQ-015 RESP_pclk SHALL be 0 in every cycle except the completion cycle.

Reset
REQ-016 While RESETn_pclk=1 at an edge, the block SHALL:
- enter S_IDLE, set READY_pclk=1 and req_pclk=0, set RESP_pclk=0;
- clear RDATA_pclk and all *_REG_pclk outputs to 0 (CMD_REG_pclk=IDLE);
- clear both synchronizer flops.
This SHALL also apply mid-transaction. The system resets the slave alongside.
REQ-017 No output SHALL be X after the first reset edge.

Structure
REQ-018 A shared package SHALL hold:
- the command code constants;
- widths: CMD_W=3, ADDR_W=10, DATA_W=10;
- the FSM state encoding.
REQ-019 One sub-module, sync_2ff (1-bit, parameterizable reset value 0), SHALL implement the synchronizer.

Verification
REQ-020 The bench SHALL cover these directed scenarios (slave model: raise ack 3 SCLK cycles after seeing req; drop ack 3 SCLK cycles after seeing req low):
- Reset -> READY_pclk=1, req_pclk=0, all REG outputs 0.
- WRITE, ADDR=0x155, WDATA=0x2AA for 1 cycle -> next cycle READY_pclk=0, REG outputs=2/0x155/0x2AA; req_pclk=1 one cycle later; RESP_pclk pulses once after ack falls; READY_pclk=1.
- READ with the slave driving RDATA_sclk=0x3C3 -> RDATA_pclk=0x3C3 at RESP_pclk.
- CMD=6 while idle -> no state change, req_pclk stays 0.
- ROW_WRITE, then CMD=ERASE and ABORT=1 mid-handshake -> CMD_REG_pclk stays 3, ABORT_REG_pclk=1, single RESP_pclk.
- Reset asserted while in S_REQ -> next cycle S_IDLE, req_pclk=0, READY_pclk=1; run with PCLK both faster and slower than SCLK.

Source files
------------

// File: rtl/master_pclk_pkg.sv
// Shared constants for the PCLK-side command master: bus widths,
// command codes and FSM state encoding.
package master_pclk_pkg;

  localparam int CMD_W  = 3;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 10;

  localparam logic [CMD_W-1:0] CMD_IDLE       = 3'd0;
  localparam logic [CMD_W-1:0] CMD_READ       = 3'd1;
  localparam logic [CMD_W-1:0] CMD_WRITE      = 3'd2;
  localparam logic [CMD_W-1:0] CMD_ROW_WRITE  = 3'd3;
  localparam logic [CMD_W-1:0] CMD_ERASE      = 3'd4;
  localparam logic [CMD_W-1:0] CMD_MASS_ERASE = 3'd5;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_SETUP = 2'd1;
  localparam logic [STATE_W-1:0] S_REQ   = 2'd2;
  localparam logic [STATE_W-1:0] S_DROP  = 2'd3;

  // Codes 6 and 7 are reserved and never start a transaction.
  function automatic logic is_valid_cmd(input logic [CMD_W-1:0] cmd);
    return (cmd >= CMD_READ) && (cmd <= CMD_MASS_ERASE);
  endfunction

endpackage

// File: rtl/master_pclk_sync_2ff.sv
// Two-flop synchronizer bringing a single asynchronous bit into the PCLK
// domain; RESET_VAL sets the value both stages take under reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic PCLK,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge PCLK) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/master_pclk.sv
// PCLK-side command master: latches a user command onto a quasi-static bus
// and runs a four-phase req/ack handshake with a slave in another clock domain.
module master_pclk
  import master_pclk_pkg::*;
(
  input  logic              PCLK,
  input  logic              RESETn_pclk,
  input  logic [CMD_W-1:0]  CMD,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              ABORT,
  output logic              READY_pclk,
  output logic [DATA_W-1:0] RDATA_pclk,
  output logic              RESP_pclk,
  input  logic [DATA_W-1:0] RDATA_sclk,
  output logic [CMD_W-1:0]  CMD_REG_pclk,
  output logic [ADDR_W-1:0] ADDR_REG_pclk,
  output logic [DATA_W-1:0] WDATA_REG_pclk,
  output logic              ABORT_REG_pclk,
  output logic              req_pclk,
  input  logic              ack_sclk,
  output logic              ack_pclk,
  input  logic              req_sclk
);

  logic [STATE_W-1:0] state;
  logic               accept;

  // req_sclk is observed by the slave side only; nothing here depends on it.
  logic unused_req_sclk;
  assign unused_req_sclk = req_sclk;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_ack_sync (
    .PCLK  (PCLK),
    .reset (RESETn_pclk),
    .d     (ack_sclk),
    .q     (ack_pclk)
  );

  assign READY_pclk = (state == S_IDLE);
  assign accept     = READY_pclk && is_valid_cmd(CMD);

  // Handshake sequencer; req and the completion pulse are registered so the
  // slave never sees a combinational glitch on req.
  always_ff @(posedge PCLK) begin
    if (RESETn_pclk) begin
      state     <= S_IDLE;
      req_pclk  <= 1'b0;
      RESP_pclk <= 1'b0;
    end else begin
      RESP_pclk <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) state <= S_SETUP;
        end
        S_SETUP: begin
          state    <= S_REQ;
          req_pclk <= 1'b1;
        end
        S_REQ: begin
          if (ack_pclk) begin
            state    <= S_DROP;
            req_pclk <= 1'b0;
          end
        end
        S_DROP: begin
          if (!ack_pclk) begin
            state     <= S_IDLE;
            RESP_pclk <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          req_pclk <= 1'b0;
        end
      endcase
    end
  end

  // Bus to the slave stays frozen while busy; only a late abort may set its flag.
  always_ff @(posedge PCLK) begin
    if (RESETn_pclk) begin
      CMD_REG_pclk   <= CMD_IDLE;
      ADDR_REG_pclk  <= '0;
      WDATA_REG_pclk <= '0;
      ABORT_REG_pclk <= 1'b0;
    end else if (accept) begin
      CMD_REG_pclk   <= CMD;
      ADDR_REG_pclk  <= ADDR;
      WDATA_REG_pclk <= WDATA;
      ABORT_REG_pclk <= ABORT;
    end else if (!READY_pclk && ABORT) begin
      ABORT_REG_pclk <= 1'b1;
    end
  end

  // Slave holds RDATA_sclk steady while ack is high, so capturing it on the
  // synchronized ack is safe without a separate data synchronizer.
  always_ff @(posedge PCLK) begin
    if (RESETn_pclk) begin
      RDATA_pclk <= '0;
    end else if (state == S_REQ && ack_pclk && CMD_REG_pclk == CMD_READ) begin
      RDATA_pclk <= RDATA_sclk;
    end
  end

endmodule

// File: tb/tb_master_pclk.sv
// Randomized and directed bench for master_pclk with a SCLK-domain slave model
// and a transaction-level reference model checked every PCLK cycle.
`timescale 1ns/100ps
module tb_master_pclk;
  import master_pclk_pkg::*;

  logic              PCLK = 1'b0;
  logic              SCLK = 1'b0;
  realtime           sclk_half = 7.0;
  logic              RESETn_pclk = 1'b1;
  logic [CMD_W-1:0]  CMD = '0;
  logic [ADDR_W-1:0] ADDR = '0;
  logic [DATA_W-1:0] WDATA = '0;
  logic              ABORT = 1'b0;
  logic              READY_pclk;
  logic [DATA_W-1:0] RDATA_pclk;
  logic              RESP_pclk;
  logic [DATA_W-1:0] RDATA_sclk;
  logic [CMD_W-1:0]  CMD_REG_pclk;
  logic [ADDR_W-1:0] ADDR_REG_pclk;
  logic [DATA_W-1:0] WDATA_REG_pclk;
  logic              ABORT_REG_pclk;
  logic              req_pclk;
  logic              ack_sclk;
  logic              ack_pclk;
  logic              req_sclk;

  int checks = 0;
  int passes = 0;

  master_pclk dut (
    .PCLK           (PCLK),
    .RESETn_pclk    (RESETn_pclk),
    .CMD            (CMD),
    .ADDR           (ADDR),
    .WDATA          (WDATA),
    .ABORT          (ABORT),
    .READY_pclk     (READY_pclk),
    .RDATA_pclk     (RDATA_pclk),
    .RESP_pclk      (RESP_pclk),
    .RDATA_sclk     (RDATA_sclk),
    .CMD_REG_pclk   (CMD_REG_pclk),
    .ADDR_REG_pclk  (ADDR_REG_pclk),
    .WDATA_REG_pclk (WDATA_REG_pclk),
    .ABORT_REG_pclk (ABORT_REG_pclk),
    .req_pclk       (req_pclk),
    .ack_sclk       (ack_sclk),
    .ack_pclk       (ack_pclk),
    .req_sclk       (req_sclk)
  );

  // PCLK edges land on whole ns, SCLK edges on x.3 ns, so the domains never tie.
  always #5 PCLK = ~PCLK;
  initial begin
    #0.3;
    forever #(sclk_half) SCLK = ~SCLK;
  end

  // Slave: raises ack 3 SCLK cycles after seeing req, drops it 3 after req falls.
  logic              slave_rst = 1'b1;
  logic [DATA_W-1:0] slave_rdata = '0;
  logic              s_req1, s_req2, s_ack;
  logic [DATA_W-1:0] s_rdata;
  int                s_cnt;

  always @(posedge SCLK) begin
    if (slave_rst) begin
      s_req1  <= 1'b0;
      s_req2  <= 1'b0;
      s_ack   <= 1'b0;
      s_rdata <= '0;
      s_cnt   <= 0;
    end else begin
      s_req1 <= req_pclk;
      s_req2 <= s_req1;
      if (s_req2 != s_ack) begin
        if (s_cnt == 2) begin
          s_ack <= s_req2;
          s_cnt <= 0;
          if (s_req2) s_rdata <= slave_rdata;
        end else begin
          s_cnt <= s_cnt + 1;
        end
      end else begin
        s_cnt <= 0;
      end
    end
  end

  assign ack_sclk   = s_ack;
  assign req_sclk   = s_req2;
  assign RDATA_sclk = s_rdata;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    else
      passes++;
  endtask

  // Reference model: a transaction is either absent or in flight; in flight it
  // waits one setup cycle, requests until ack is seen, then waits for ack to clear.
  bit                m_valid = 1'b0;
  bit                m_busy, m_setup, m_req, m_resp, m_abort;
  bit                m_ack1, m_ack2;
  logic [CMD_W-1:0]  m_cmd;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  always @(posedge PCLK) begin
    if (RESETn_pclk) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b0;
      m_setup <= 1'b0;
      m_req   <= 1'b0;
      m_resp  <= 1'b0;
      m_abort <= 1'b0;
      m_ack1  <= 1'b0;
      m_ack2  <= 1'b0;
      m_cmd   <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_rdata <= '0;
    end else begin
      m_ack1 <= ack_sclk;
      m_ack2 <= m_ack1;
      m_resp <= 1'b0;
      if (!m_busy) begin
        if (CMD >= 3'd1 && CMD <= 3'd5) begin
          m_busy  <= 1'b1;
          m_setup <= 1'b1;
          m_cmd   <= CMD;
          m_addr  <= ADDR;
          m_wdata <= WDATA;
          m_abort <= ABORT;
        end
      end else begin
        if (ABORT) m_abort <= 1'b1;
        if (m_setup) begin
          m_setup <= 1'b0;
          m_req   <= 1'b1;
        end else if (m_req) begin
          if (m_ack2) begin
            m_req <= 1'b0;
            if (m_cmd == 3'd1) m_rdata <= RDATA_sclk;
          end
        end else if (!m_ack2) begin
          m_busy <= 1'b0;
          m_resp <= 1'b1;
        end
      end
    end
  end

  always @(negedge PCLK) begin
    if (m_valid) begin
      check_output("ready",    READY_pclk,     !m_busy);
      check_output("req",      req_pclk,       m_req);
      check_output("resp",     RESP_pclk,      m_resp);
      check_output("ack_pclk", ack_pclk,       m_ack2);
      check_output("rdata",    RDATA_pclk,     m_rdata);
      check_output("cmd_reg",  CMD_REG_pclk,   m_cmd);
      check_output("addr_reg", ADDR_REG_pclk,  m_addr);
      check_output("wdata_reg",WDATA_REG_pclk, m_wdata);
      check_output("abort_reg",ABORT_REG_pclk, m_abort);
    end
  end

  // Drive one command for a single cycle, return on the negedge after it was sampled.
  task automatic apply_stimulus(input logic [2:0] c, input logic [9:0] a,
                                input logic [9:0] w, input logic ab);
    @(negedge PCLK);
    CMD = c; ADDR = a; WDATA = w; ABORT = ab;
    @(negedge PCLK);
    CMD = '0; ABORT = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge PCLK);
    RESETn_pclk = 1'b1;
    slave_rst   = 1'b1;
    repeat (cycles) @(negedge PCLK);
    RESETn_pclk = 1'b0;
    slave_rst   = 1'b0;
  endtask

  task automatic wait_resp(input int budget, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge PCLK);
      n++;
      if (RESP_pclk === 1'b1) seen = 1'b1;
    end
    check_output({name, "_resp_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic reset_in_req(input string name);
    apply_stimulus(CMD_WRITE, 10'h0F0, 10'h00F, 1'b0);
    @(negedge PCLK);
    check_output({name, "_req_before"}, req_pclk, 1'b1);
    RESETn_pclk = 1'b1;
    slave_rst   = 1'b1;
    @(negedge PCLK);
    check_output({name, "_req_after"},   req_pclk,     1'b0);
    check_output({name, "_ready_after"}, READY_pclk,   1'b1);
    check_output({name, "_cmdreg_after"},CMD_REG_pclk, 3'd0);
    repeat (6) @(negedge PCLK);
    RESETn_pclk = 1'b0;
    slave_rst   = 1'b0;
  endtask

  task automatic random_traffic(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge PCLK);
      CMD         = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      ADDR        = 10'($urandom);
      WDATA       = 10'($urandom);
      ABORT       = ($urandom_range(0, 15) == 0);
      slave_rdata = 10'($urandom);
    end
    @(negedge PCLK);
    CMD = '0; ABORT = 1'b0;
  endtask

  initial begin
    int extra;
    $display("[TB] start");
    do_reset(6);
    check_output("rst_ready", READY_pclk,     1'b1);
    check_output("rst_req",   req_pclk,       1'b0);
    check_output("rst_resp",  RESP_pclk,      1'b0);
    check_output("rst_cmd",   CMD_REG_pclk,   3'd0);
    check_output("rst_addr",  ADDR_REG_pclk,  10'h000);
    check_output("rst_wdata", WDATA_REG_pclk, 10'h000);
    check_output("rst_abort", ABORT_REG_pclk, 1'b0);
    check_output("rst_rdata", RDATA_pclk,     10'h000);

    apply_stimulus(CMD_WRITE, 10'h155, 10'h2AA, 1'b0);
    check_output("wr_ready",  READY_pclk,     1'b0);
    check_output("wr_cmd",    CMD_REG_pclk,   3'd2);
    check_output("wr_addr",   ADDR_REG_pclk,  10'h155);
    check_output("wr_wdata",  WDATA_REG_pclk, 10'h2AA);
    check_output("wr_setup_req", req_pclk,    1'b0);
    @(negedge PCLK);
    check_output("wr_req",    req_pclk,       1'b1);
    wait_resp(200, "wr");
    check_output("wr_ready_at_resp", READY_pclk, 1'b1);

    slave_rdata = 10'h3C3;
    apply_stimulus(CMD_READ, 10'h001, 10'h000, 1'b0);
    wait_resp(200, "rd");
    check_output("rd_rdata", RDATA_pclk, 10'h3C3);

    apply_stimulus(3'd6, 10'h3FF, 10'h3FF, 1'b0);
    check_output("inv_ready", READY_pclk,   1'b1);
    check_output("inv_cmd",   CMD_REG_pclk, 3'd1);
    @(negedge PCLK);
    check_output("inv_req",   req_pclk,     1'b0);

    apply_stimulus(CMD_ROW_WRITE, 10'h0AA, 10'h155, 1'b0);
    @(negedge PCLK);
    CMD = CMD_ERASE; ABORT = 1'b1;
    @(negedge PCLK);
    CMD = '0; ABORT = 1'b0;
    check_output("rw_cmd",   CMD_REG_pclk,   3'd3);
    check_output("rw_abort", ABORT_REG_pclk, 1'b1);
    wait_resp(200, "rw");
    check_output("rw_abort_held", ABORT_REG_pclk, 1'b1);
    extra = 0;
    repeat (30) begin
      @(negedge PCLK);
      if (RESP_pclk === 1'b1) extra++;
    end
    check_output("rw_extra_resp", 32'(extra), 32'd0);

    sclk_half = 7.0;
    reset_in_req("rst_req_slow_sclk");
    random_traffic(500);
    sclk_half = 3.0;
    repeat (4) @(negedge PCLK);
    reset_in_req("rst_req_fast_sclk");
    random_traffic(500);
    sclk_half = 2.0;
    repeat (4) @(negedge PCLK);
    random_traffic(300);
    repeat (60) @(negedge PCLK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
